kernel_ctrl: RTL and testbench

//  Receives a K_DIM x K_DIM convolution kernel as an AXI-Stream of columns, one column per beat.

---
 rtl/kernel_ctrl.sv | 86 ++++++++
 tb/tb_kernel_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/kernel_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : kernel_ctrl                                              |
// | Description : Assembles a column-streamed KxK kernel into a parallel   |
// |               matrix for the multiplier array.                         |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module kernel_ctrl #(
  parameter int K_DIM  = 3,
  parameter int I_DIM  = 8,
  parameter int M_BITS = 16,
  parameter int M_CNT  = 16,
  parameter int K_SIZE = K_DIM * K_DIM,
  parameter int K_BITS = $clog2(K_DIM + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  output logic                                   in_ready,
  input  logic [K_DIM-1:0][M_BITS-1:0]           in_data,
  input  logic                                   in_last,
  input  logic                                   in_valid,
  output logic                                   out_valid,
  output logic [K_DIM-1:0][K_DIM-1:0][M_BITS-1:0] out_data
);

  localparam logic [K_BITS-1:0] c_last_col = K_BITS'(K_DIM - 1);

  // Parameters kept only for interface uniformity are referenced here so a
  // nonsensical configuration is at least visible at elaboration.
  if (I_DIM < 1 || M_CNT < 1 || K_SIZE != K_DIM * K_DIM) begin : g_cfg_invalid
  end

  logic                                    r_ready;
  logic                                    r_out_valid;
  logic [K_BITS-1:0]                       r_col;
  logic [K_DIM-1:0][K_DIM-1:0][M_BITS-1:0] r_staging;
  logic [K_DIM-1:0][K_DIM-1:0][M_BITS-1:0] r_out_data;

  logic                                    w_accept;
  logic                                    w_commit;
  logic [K_DIM-1:0][K_DIM-1:0][M_BITS-1:0] w_merged;

  always_comb begin
    w_accept = in_valid & r_ready;
    w_commit = w_accept & (in_last | (r_col == c_last_col));
    w_merged = r_staging;
    for (int r = 0; r < K_DIM; r++) begin
      for (int c = 0; c < K_DIM; c++) begin
        if (r_col == K_BITS'(c)) begin
          w_merged[r][c] = in_data[r];
        end
      end
    end
  end

  // On commit the current beat is merged straight into the output so the
  // last column never has to pass through the staging buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready     <= 1'b0;
      r_out_valid <= 1'b0;
      r_col       <= '0;
      r_staging   <= '0;
      r_out_data  <= '0;
    end else begin
      r_ready     <= 1'b1;
      r_out_valid <= w_commit;
      if (w_accept) begin
        if (w_commit) begin
          r_out_data <= w_merged;
          r_staging  <= '0;
          r_col      <= '0;
        end else begin
          r_staging  <= w_merged;
          r_col      <= r_col + K_BITS'(1);
        end
      end
    end
  end

  assign in_ready  = r_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_kernel_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_kernel_ctrl                                           |
// | Description : Directed self-checking bench for kernel_ctrl.            |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_kernel_ctrl;

  typedef logic [2:0][2:0][15:0] kmat_t;

  logic                clk;
  logic                rst;
  logic                in_ready;
  logic [2:0][15:0]    in_data;
  logic                in_last;
  logic                in_valid;
  logic                out_valid;
  kmat_t               out_data;

  int n_vec;
  int n_err;

  kernel_ctrl #(
    .K_DIM (3),
    .I_DIM (8),
    .M_BITS(16),
    .M_CNT (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_valid (in_valid),
    .out_valid(out_valid),
    .out_data (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected kernel whose column c holds base_c + row.
  function automatic kmat_t kern(int b0, int b1, int b2);
    kmat_t k;
    int    b [3];
    b[0] = b0; b[1] = b1; b[2] = b2;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        k[r][c] = 16'(b[c] + r);
    return k;
  endfunction

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one beat (column values base+r) and advance past the edge; valid stays high.
  task automatic beat(input int base, input logic last);
    in_valid = 1'b1;
    in_last  = last;
    for (int r = 0; r < 3; r++) in_data[r] = 16'(base + r);
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = {16'hdead, 16'hbeef, 16'hcafe};
    tick();
  endtask

  initial begin
    kmat_t ka;
    kmat_t kb;
    kmat_t ke;
    n_vec = 0;
    n_err = 0;
    ka = kern(0, 10, 20);
    kb = kern(30, 20, 10);

    // 1: reset
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    tick(); tick();
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, '0);
    rst = 1'b0;
    #1;
    chk("release_ready_before_edge", in_ready, 0);
    tick();
    chk("release_ready", in_ready, 1);

    // 2: kernel A back-to-back beats
    beat(0, 1'b0);
    chk("a_b0_valid", out_valid, 0);
    beat(10, 1'b0);
    chk("a_b1_valid", out_valid, 0);
    beat(20, 1'b1);
    chk("a_valid", out_valid, 1);
    chk("a_data", out_data, ka);
    idle();
    chk("a_pulse_end", out_valid, 0);
    chk("a_hold", out_data, ka);

    // 3: kernel B after the idle cycle; A must stay until B commits
    beat(30, 1'b0);
    chk("b_b0_hold", out_data, ka);
    beat(20, 1'b0);
    chk("b_b1_valid", out_valid, 0);
    chk("b_b1_hold", out_data, ka);
    beat(10, 1'b1);
    chk("b_valid", out_valid, 1);
    chk("b_data", out_data, kb);
    idle();
    chk("b_pulse_end", out_valid, 0);
    chk("b_hold", out_data, kb);

    // 4: gaps between beats
    beat(0, 1'b0);
    idle(); chk("gap1_valid", out_valid, 0);
    idle(); chk("gap2_valid", out_valid, 0);
    beat(10, 1'b0);
    idle(); idle();
    chk("gap_hold", out_data, kb);
    beat(20, 1'b1);
    chk("gap_valid", out_valid, 1);
    chk("gap_data", out_data, ka);
    idle();
    chk("gap_pulse_end", out_valid, 0);

    // 5: early last, then next kernel from column 0 with implicit last
    beat(0, 1'b0);
    beat(10, 1'b1);
    ke = kern(0, 10, 0);
    for (int r = 0; r < 3; r++) ke[r][2] = 16'h0;
    chk("early_valid", out_valid, 1);
    chk("early_data", out_data, ke);
    beat(40, 1'b0);
    chk("early_pulse_end", out_valid, 0);
    beat(50, 1'b0);
    beat(60, 1'b0);
    chk("implicit_valid", out_valid, 1);
    chk("implicit_data", out_data, kern(40, 50, 60));
    idle();

    // 6: reset mid-kernel, then kernel A followed back-to-back by kernel B
    beat(70, 1'b0);
    beat(80, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_data", out_data, '0);
    chk("midrst_ready", in_ready, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_ready_back", in_ready, 1);
    beat(0, 1'b0);
    beat(10, 1'b0);
    beat(20, 1'b1);
    chk("midrst_valid", out_valid, 1);
    chk("midrst_data_a", out_data, ka);
    beat(30, 1'b0);
    chk("b2b_pulse_end", out_valid, 0);
    beat(20, 1'b0);
    beat(10, 1'b1);
    chk("b2b_valid", out_valid, 1);
    chk("b2b_data", out_data, kb);
    idle();
    chk("b2b_pulse_end2", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
